// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and constants for the APB round-robin arbiter.
// Holds the FSM state encoding and the sizing helper for the timeout counter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Counter wide enough to hold every value from 0 to TIMEOUT.
  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid request after last_grant,
// wrapping modulo N; returns one-hot grant, encoded index and any-valid.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_valid
);

  logic [IDX_W-1:0] cand_idx [N];

  // cand_idx[gi] is the requester checked at search position gi.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((int'(last_grant) + gi + 1) % N);
    end
  endgenerate

  // Walk from the lowest priority upward so the closest candidate wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[cand_idx[i]]) begin
        grant              = '0;
        grant[cand_idx[i]] = 1'b1;
        grant_idx          = cand_idx[i];
        any_valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one APB requester port between NUM_REQ command sources using
// round-robin arbitration, wait-state handling and a hung-transfer timeout.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]         req_write_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic [ADDR_W-1:0]          paddr_o,
  output logic                       pwrite_o,
  output logic [DATA_W-1:0]          pwdata_o,
  input  logic                       pready_i,
  input  logic [DATA_W-1:0]          prdata_i,
  input  logic                       pslverr_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = tmo_cnt_w(TIMEOUT);

  state_t             state_reg;
  logic [IDX_W-1:0]   last_grant_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [CNT_W-1:0]   wait_cnt_reg;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_write;
  logic [DATA_W-1:0]  sel_wdata;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req_valid_i),
    .last_grant (last_grant_reg),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .any_valid  (pick_any)
  );

  assign req_ready_o = (state_reg == IDLE) ? pick_grant : '0;
  assign sel_addr    = req_addr_i[pick_idx*ADDR_W +: ADDR_W];
  assign sel_write   = req_write_i[pick_idx];
  assign sel_wdata   = req_wdata_i[pick_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      owner_reg      <= '0;
      wait_cnt_reg   <= '0;
      psel_o         <= 1'b0;
      penable_o      <= 1'b0;
      paddr_o        <= '0;
      pwrite_o       <= 1'b0;
      pwdata_o       <= '0;
      rsp_valid_o    <= '0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            psel_o         <= 1'b1;
            penable_o      <= 1'b0;
            paddr_o        <= sel_addr;
            pwrite_o       <= sel_write;
            pwdata_o       <= sel_write ? sel_wdata : '0;
            last_grant_reg <= pick_idx;
            owner_reg      <= pick_idx;
            wait_cnt_reg   <= '0;
            state_reg      <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          // Completion and abort share the bus-release path; only the
          // response payload differs.
          if (pready_i || (wait_cnt_reg == CNT_W'(TIMEOUT - 1))) begin
            psel_o                 <= 1'b0;
            penable_o              <= 1'b0;
            paddr_o                <= '0;
            pwrite_o               <= 1'b0;
            pwdata_o               <= '0;
            rsp_valid_o[owner_reg] <= 1'b1;
            state_reg              <= IDLE;
            if (pready_i) begin
              rsp_err_o   <= pslverr_i;
              rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            end else begin
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Shares one APB requester port between NUM_REQ internal command sources.
- Round-robin arbitration with a simple valid/ready request channel and a one-cycle response pulse per requester.
- Sequences APB SETUP/ACCESS phases, honours pready wait states, captures prdata/pslverr and aborts hung transfers with a timeout.
- Sits between per-function command generators (e.g. read-modify-write sequencers) and the APB fabric.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 32: APB address width.
- DATA_W, 32: APB data width.
- TIMEOUT, 16: maximum ACCESS cycles waiting for pready before abort; must be at least 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  request pending, one bit per requester.
- req_ready_o  out  NUM_REQ  request accepted this cycle, one-hot or zero.
- req_addr_i  in  NUM_REQ*ADDR_W  flattened addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- req_write_i  in  NUM_REQ  1 = write, 0 = read.
- req_wdata_i  in  NUM_REQ*DATA_W  flattened write data.
- rsp_valid_o  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata_o  out  DATA_W  read data, shared by all requesters, valid with rsp_valid_o.
- rsp_err_o  out  1  pslverr or timeout, valid with rsp_valid_o.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- paddr_o  out  ADDR_W  APB address.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_W  APB write data.
- pready_i  in  1  APB ready.
- prdata_i  in  DATA_W  APB read data.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset values:
  - psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_rdata_o and rsp_err_o are all 0.
  - State is IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - req_ready_o is combinational: one-hot on the first requester with req_valid_i set, searching last_grant+1, last_grant+2, ... with wrap-around modulo NUM_REQ.
  - If no requester is valid, req_ready_o is 0.
  - On handshake, the granted addr/write/wdata are registered, last_grant and the owner index are updated, and the FSM goes to SETUP.
- SETUP (1 cycle): psel_o=1, penable_o=0; paddr_o, pwrite_o and pwdata_o carry the latched transfer (pwdata_o is 0 for reads). Next state is ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; address, direction and data are held stable.
  - A wait counter increments each cycle that pready_i=0.
  - pready_i=1: the transfer completes. Next cycle rsp_valid_o[owner]=1, rsp_err_o=pslverr_i, and rsp_rdata_o=prdata_i for reads (0 for writes). psel_o, penable_o, paddr_o, pwrite_o and pwdata_o return to 0. Next state is IDLE.
  - Wait count reaches TIMEOUT with pready_i still 0: abort. Next cycle rsp_valid_o[owner]=1, rsp_err_o=1, rsp_rdata_o=0, APB signals return to 0. Next state is IDLE.
- rsp_valid_o is high for exactly one cycle; rsp_rdata_o and rsp_err_o hold their values until the next response.
- Minimum latency: handshake at cycle T, SETUP at T+1, ACCESS at T+2, pready at T+2, rsp_valid at T+3. A new grant may occur in that same T+3 cycle, giving a throughput of one transfer per 3 cycles.
- No request is accepted outside IDLE; req_ready_o is 0 there.
- Requesters must hold req_valid_i and their request fields until ready.
- A requester dropping valid before ready is legal; it is simply not granted.
- pready_i is ignored outside ACCESS.
- pslverr_i is sampled only together with pready_i in ACCESS.
- Reset asserted in any state, including mid-ACCESS, returns everything to reset values on the next edge. No response is issued for the killed transfer, and the pointer is reset.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - width of the timeout counter, $clog2(TIMEOUT+1);
  - default width constants.
- Sub-module rr_pick:
  - combinational round-robin selector;
  - inputs: request vector and last_grant;
  - outputs: one-hot grant, encoded index and any-valid.

Test Plan:
- Single read: req_valid_i[0]=1, read of 0xDEAD_CAFE; slave returns pready=1 in the first ACCESS cycle with prdata=0x1234_5678 -> req_ready_o=4'b0001 at T; SETUP at T+1; ACCESS at T+2; rsp_valid_o=4'b0001, rsp_rdata_o=0x1234_5678, rsp_err_o=0 at T+3.
- Fairness: all four requesters valid continuously, zero-wait slave -> grants in order 0,1,2,3,0, one grant every 3 cycles, each rsp_valid_o on the correct bit.
- Wait states plus write: requester 2 writes 0x0000_0005 to 0xDEAD_CAFE; pready delayed 3 cycles -> penable_o held 4 cycles; paddr_o and pwdata_o stable throughout; rsp_valid_o[2] on the cycle after pready.
- Slave error: read with pready=1 and pslverr=1 -> rsp_err_o=1; the next transfer's response shows rsp_err_o=0.
- Timeout: pready held 0 with TIMEOUT=16 -> psel_o drops after 16 ACCESS cycles; rsp_valid_o[owner]=1, rsp_err_o=1, rsp_rdata_o=0; the next pending requester is granted afterwards.
- Reset mid-ACCESS: assert reset during a wait state -> all outputs 0 on the next edge; no rsp_valid_o; after release, requester 0 wins over requester 3 when both are valid.
